nal_epb_remover: RTL and testbench

Byte-to-word front end that sits directly upstream of the bitstream buffer. It takes the raw NAL payload one byte at a time and strips emulation-prevention bytes (0x03 following 0x00 0x00). It packs the surviving bytes MSB-first into 16-bit words and presents them to the buffer with the we/next handshake, together with the 2-bit remove_03 flag the buffer records per word.

---
 rtl/nal_epb_remover_if.sv | 24 ++
 rtl/nal_epb_remover.sv | 131 +++++++++++++
 tb/tb_nal_epb_remover.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/nal_epb_remover_if.sv
// Byte-in / word-out handshake bundle for the EPB remover.
// slave is the remover's view; master is the producer/buffer side.
interface nal_epb_remover_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        nal_start;
    logic        flush;
    logic        epb_en;
    logic [15:0] BitStream_buffer_input;
    logic        we;
    logic        next;
    logic [1:0]  remove_03_flag;

    modport slave (
        input  byte_in, byte_valid, nal_start, flush, epb_en, next,
        output byte_ready, BitStream_buffer_input, we, remove_03_flag
    );

    modport master (
        output byte_in, byte_valid, nal_start, flush, epb_en, next,
        input  byte_ready, BitStream_buffer_input, we, remove_03_flag
    );
endinterface

// File: rtl/nal_epb_remover.sv
// Strips 0x000003 emulation-prevention bytes and packs survivors
// MSB-first into 16-bit words for the bitstream buffer.
module nal_epb_remover #(
    parameter int unsigned CNT_W          = 16,
    parameter bit          EPB_EN_DEFAULT = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nal_epb_remover_if.slave     bus,
    output logic [CNT_W-1:0]     epb_count,
    output logic                 busy
);
    typedef enum logic {EMPTY, HALF} col_e;

    col_e             state_q, state_d;
    logic [7:0]       hi_q, hi_d;
    logic             hi_flag_q, hi_flag_d;
    logic             pend_q, pend_d;
    logic [1:0]       zcnt_q, zcnt_d;
    logic [15:0]      word_q, word_d;
    logic [1:0]       flag_q, flag_d;
    logic             we_q, we_d;
    logic             fpend_q, fpend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;

    logic       out_free, accept, is_epb, do_flush, en;
    logic [1:0] zc;
    logic       pf;

    always_comb begin
        out_free = !we_q || bus.next;
        bus.byte_ready = !bus.flush && !fpend_q
                         && (state_q == EMPTY || out_free);
        accept = bus.byte_valid && bus.byte_ready;
        // nal_start wipes the run/flag before this byte is judged
        zc = bus.nal_start ? 2'd0 : zcnt_q;
        pf = bus.nal_start ? 1'b0 : pend_q;
        en = accept ? bus.epb_en : en_q;
        is_epb = en && zc == 2'd2 && bus.byte_in == 8'h03;
        do_flush = (bus.flush || fpend_q) && state_q == HALF && out_free;
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        hi_flag_d = hi_flag_q;
        pend_d    = pend_q;
        zcnt_d    = zcnt_q;
        word_d    = word_q;
        flag_d    = flag_q;
        we_d      = we_q;
        fpend_d   = fpend_q;
        cnt_d     = cnt_q;
        en_d      = en;

        if (we_q && bus.next)
            we_d = 1'b0;

        if (bus.flush && state_q == HALF && !out_free)
            fpend_d = 1'b1;

        if (do_flush) begin
            word_d  = {hi_q, 8'h00};
            flag_d  = hi_flag_q ? 2'd1 : 2'd0;
            we_d    = 1'b1;
            fpend_d = 1'b0;
            state_d = EMPTY;
        end

        if (accept) begin
            pend_d = pf;
            if (is_epb) begin
                zcnt_d = 2'd0;
                pend_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}})
                    cnt_d = cnt_q + 1'b1;
            end else begin
                if (bus.byte_in == 8'h00)
                    zcnt_d = (zc == 2'd2) ? 2'd2 : zc + 2'd1;
                else
                    zcnt_d = 2'd0;
                pend_d = 1'b0;
                if (state_q == EMPTY) begin
                    hi_d      = bus.byte_in;
                    hi_flag_d = pf;
                    state_d   = HALF;
                end else begin
                    word_d  = {hi_q, bus.byte_in};
                    flag_d  = hi_flag_q ? 2'd1 : (pf ? 2'd2 : 2'd0);
                    we_d    = 1'b1;
                    state_d = EMPTY;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            hi_q      <= 8'h00;
            hi_flag_q <= 1'b0;
            pend_q    <= 1'b0;
            zcnt_q    <= 2'd0;
            word_q    <= 16'h0000;
            flag_q    <= 2'd0;
            we_q      <= 1'b0;
            fpend_q   <= 1'b0;
            cnt_q     <= '0;
            en_q      <= EPB_EN_DEFAULT;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            hi_flag_q <= hi_flag_d;
            pend_q    <= pend_d;
            zcnt_q    <= zcnt_d;
            word_q    <= word_d;
            flag_q    <= flag_d;
            we_q      <= we_d;
            fpend_q   <= fpend_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
        end
    end

    assign bus.BitStream_buffer_input = word_q;
    assign bus.we                     = we_q;
    assign bus.remove_03_flag         = flag_q;
    assign epb_count                  = cnt_q;
    assign busy = (state_q == HALF) || we_q || fpend_q;
endmodule

// File: tb/tb_nal_epb_remover.sv
// Directed bench for nal_epb_remover: packing, EPB removal,
// backpressure, flush and asynchronous reset.
module tb_nal_epb_remover;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] epb_count;
    logic        busy;
    int          chk = 0;
    int          err = 0;
    logic [17:0] q[$];

    nal_epb_remover_if bus ();

    nal_epb_remover #(.CNT_W(16), .EPB_EN_DEFAULT(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .epb_count (epb_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // record every word that transfers (we && next) in order
    always @(negedge clk)
        if (reset_n && bus.we && bus.next)
            q.push_back({bus.remove_03_flag, bus.BitStream_buffer_input});

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        chk++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.byte_valid = 1'b0;
        bus.nal_start = 1'b0;
        bus.flush = 1'b0;
        bus.epb_en = 1'b1;
        bus.next = 1'b1;
        bus.byte_in = 8'h00;
        repeat (2) @(posedge clk);
        q.delete();
        #1 reset_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic ns);
        logic ok;
        ok = 1'b0;
        bus.byte_in = b;
        bus.byte_valid = 1'b1;
        bus.nal_start = ns;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.byte_ready;
            @(posedge clk);
            #1;
        end
        bus.byte_valid = 1'b0;
        bus.nal_start = 1'b0;
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.nal_start = 1'b0;
        bus.flush = 1'b0;
        bus.epb_en = 1'b1;
        bus.next = 1'b1;
        bus.byte_in = 8'h00;

        // reset state
        do_reset();
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_word", 32'(bus.BitStream_buffer_input), 32'd0);
        check("rst_flag", 32'(bus.remove_03_flag), 32'd0);
        check("rst_cnt", 32'(epb_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.byte_ready), 32'd1);

        // plain packing and one-cycle latency
        send(8'h12, 1'b1);
        check("t1_we_half", 32'(bus.we), 32'd0);
        send(8'h34, 1'b0);
        check("t1_we0", 32'(bus.we), 32'd1);
        check("t1_word0", 32'(bus.BitStream_buffer_input), 32'h1234);
        send(8'h56, 1'b0);
        check("t1_we_drop", 32'(bus.we), 32'd0);
        send(8'h78, 1'b0);
        check("t1_we1", 32'(bus.we), 32'd1);
        check("t1_word1", 32'(bus.BitStream_buffer_input), 32'h5678);
        drain();
        check("t1_n", q.size(), 32'd2);
        check("t1_q0", 32'(q[0]), {14'd0, 2'd0, 16'h1234});
        check("t1_q1", 32'(q[1]), {14'd0, 2'd0, 16'h5678});
        check("t1_busy", 32'(busy), 32'd0);

        // EPB before a high byte
        do_reset();
        send(8'h00, 1'b1);
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        send(8'h01, 1'b0);
        send(8'hAB, 1'b0);
        send(8'hCD, 1'b0);
        drain();
        check("t2_n", q.size(), 32'd2);
        check("t2_q0", 32'(q[0]), {14'd0, 2'd0, 16'h0000});
        check("t2_q1", 32'(q[1]), {14'd0, 2'd1, 16'h01AB});
        check("t2_cnt", 32'(epb_count), 32'd1);
        check("t2_busy", 32'(busy), 32'd1);

        // saturated zero run, EPB before a low byte
        do_reset();
        send(8'h00, 1'b1);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        send(8'h02, 1'b0);
        send(8'h0F, 1'b0);
        drain();
        check("t3_n", q.size(), 32'd2);
        check("t3_q0", 32'(q[0]), {14'd0, 2'd0, 16'h0000});
        check("t3_q1", 32'(q[1]), {14'd0, 2'd2, 16'h0002});
        check("t3_cnt", 32'(epb_count), 32'd1);
        check("t3_busy", 32'(busy), 32'd1);

        // two EPBs in one payload
        do_reset();
        send(8'h00, 1'b1);
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        send(8'h05, 1'b0);
        send(8'h77, 1'b0);
        drain();
        check("t4_n", q.size(), 32'd3);
        check("t4_q0", 32'(q[0]), {14'd0, 2'd0, 16'h0000});
        check("t4_q1", 32'(q[1]), {14'd0, 2'd1, 16'h0000});
        check("t4_q2", 32'(q[2]), {14'd0, 2'd1, 16'h0577});
        check("t4_cnt", 32'(epb_count), 32'd2);

        // backpressure
        do_reset();
        bus.next = 1'b0;
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_we", 32'(bus.we), 32'd1);
            check("t5_hold_word", 32'(bus.BitStream_buffer_input), 32'h1122);
            check("t5_ready", 32'(bus.byte_ready), 32'd0);
        end
        @(posedge clk);
        #1 bus.next = 1'b1;
        send(8'h44, 1'b0);
        drain();
        check("t5_n", q.size(), 32'd2);
        check("t5_q0", 32'(q[0]), {14'd0, 2'd0, 16'h1122});
        check("t5_q1", 32'(q[1]), {14'd0, 2'd0, 16'h3344});

        // epb_en=0 keeps everything
        do_reset();
        bus.epb_en = 1'b0;
        send(8'h00, 1'b1);
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        drain();
        check("t6_n", q.size(), 32'd2);
        check("t6_q1", 32'(q[1]), {14'd0, 2'd0, 16'h0304});
        check("t6_cnt", 32'(epb_count), 32'd0);
        bus.epb_en = 1'b1;

        // nal_start protects a leading 0x03
        do_reset();
        send(8'h00, 1'b1);
        send(8'h00, 1'b0);
        send(8'h03, 1'b1);
        send(8'h07, 1'b0);
        drain();
        check("t7_n", q.size(), 32'd2);
        check("t7_q1", 32'(q[1]), {14'd0, 2'd0, 16'h0307});
        check("t7_cnt", 32'(epb_count), 32'd0);

        // flush an odd byte
        do_reset();
        send(8'h9A, 1'b1);
        check("t8_busy_half", 32'(busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("t8_we", 32'(bus.we), 32'd1);
        check("t8_word", 32'(bus.BitStream_buffer_input), 32'h9A00);
        check("t8_flag", 32'(bus.remove_03_flag), 32'd0);
        drain();
        check("t8_busy", 32'(busy), 32'd0);
        check("t8_n", q.size(), 32'd1);

        // asynchronous reset mid-operation
        do_reset();
        bus.next = 1'b0;
        send(8'h00, 1'b1);
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        send(8'h55, 1'b0);
        check("t9_cnt_pre", 32'(epb_count), 32'd1);
        check("t9_busy_pre", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t9_we", 32'(bus.we), 32'd0);
        check("t9_busy", 32'(busy), 32'd0);
        check("t9_cnt", 32'(epb_count), 32'd0);
        check("t9_word", 32'(bus.BitStream_buffer_input), 32'd0);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
